// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bundle: instruction-memory handshake, decode-side instruction
// register outputs and retire/next-PC inputs. master = fetch_sequencer.
interface fetch_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [31:0]     instruction;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] pc_plus4;
  logic            instr_valid;
  logic            retire;
  logic [1:0]      pcsrc;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] alu_result;
  logic            halted;
  logic            fetch_fault;

  modport master (
    output imem_req, imem_addr, instruction, instr_pc, pc_plus4,
           instr_valid, halted, fetch_fault,
    input  imem_ack, imem_rdata, retire, pcsrc, imm_ext, alu_result
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_pc, pc_plus4,
           instr_valid, halted, fetch_fault,
    output imem_ack, imem_rdata, retire, pcsrc, imm_ext, alu_result
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch stage: owns the PC, fetches over req/ack, holds the word
// until retire. Define FETCH_MISALIGN_TRAP_EN to trap on a misaligned next PC.
module fetch_sequencer #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic clk,
  input  logic rst,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {FETCH, HOLD, HALT, FAULT} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next, target;
  logic [31:0]     instruction;
  logic [XLEN-1:0] instr_pc, pc_plus4;

  always_comb begin
    target = pc;
    case (bus.pcsrc)
      2'b01:   target = instr_pc + bus.imm_ext;
      2'b10:   target = pc_plus4;
      2'b11:   target = bus.alu_result & ~XLEN'(1);
      default: target = pc;
    endcase
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      FETCH: if (bus.imem_ack) state_next = HOLD;
      HOLD: begin
        if (bus.retire) begin
          if (bus.pcsrc == 2'b00) begin
            state_next = HALT;
          end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
            pc_next    = target;
            state_next = (target[1:0] != 2'b00) ? FAULT : FETCH;
`else
            pc_next    = target & ~XLEN'(3);
            state_next = FETCH;
`endif
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= NOP_INSTR;
      instr_pc    <= RESET_PC;
      pc_plus4    <= RESET_PC + XLEN'(4);
    end else if (state == FETCH && bus.imem_ack) begin
      instruction <= bus.imem_rdata;
      instr_pc    <= pc;
      pc_plus4    <= pc + XLEN'(4);
    end
  end

  // Status flags decode straight from the state register, so they are registered.
  assign bus.imem_req    = (state == FETCH);
  assign bus.imem_addr   = pc;
  assign bus.instruction = instruction;
  assign bus.instr_pc    = instr_pc;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.instr_valid = (state == HOLD);
  assign bus.halted      = (state == HALT);
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.fetch_fault = (state == FAULT);
`else
  assign bus.fetch_fault = 1'b0;
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction fetch stage that owns the program counter, requests instructions from instruction memory over a req/ack handshake, and holds the fetched word in an instruction register. The instruction register feeds the decode/control stage directly upstream of the datapath. On each retire, the block consumes that stage's 2-bit `pcsrc` select, together with the immediate and ALU result, to form the next PC.

## Interface
Parameters:
- `XLEN`, 32, datapath/PC width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, instruction register value when no valid instruction is held (addi x0,x0,0).

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  XLEN  fetch address, equals current PC.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instruction`  out  32  instruction register, drives the control stage.
- `instr_pc`  out  XLEN  PC of the held instruction.
- `pc_plus4`  out  XLEN  `instr_pc + 4`, used for the jal link value.
- `instr_valid`  out  1  `instruction` is valid and awaiting retire.
- `retire`  in  1  datapath finished the held instruction; `pcsrc`, `imm_ext`, `alu_result` are sampled this cycle.
- `pcsrc`  in  2  next-PC select: 00 halt, 01 `instr_pc + imm_ext`, 10 `pc_plus4`, 11 `{alu_result[XLEN-1:1],1'b0}`.
- `imm_ext`  in  XLEN  sign-extended immediate.
- `alu_result`  in  XLEN  jalr target.
- `halted`  out  1  fetch stopped until reset.
- `fetch_fault`  out  1  misaligned next PC detected (see Configuration).

## Operation
- States: FETCH, HOLD, HALT, FAULT.
- FETCH:
  - `imem_req=1`, `imem_addr=pc`, `instr_valid=0`.
  - On `imem_ack`: `instruction<=imem_rdata`, `instr_pc<=pc`, go to HOLD.
  - Without ack: stay in FETCH. `imem_addr` stays stable while `imem_req` is high.
- HOLD:
  - `imem_req=0`, `instr_valid=1`.
  - On `retire`, next PC is computed from `pcsrc`:
    - 01: `next = instr_pc + imm_ext`.
    - 10: `next = instr_pc + 4`.
    - 11: `next = alu_result` with bit 0 cleared.
    - All three: `pc<=next`, go to FETCH.
    - 00: go to HALT; `pc` unchanged.
- HALT: `halted=1`, `imem_req=0`, `instr_valid=0`. The only exit is reset.
- FAULT: `fetch_fault=1`, `imem_req=0`, `instr_valid=0`, `pc` holds the offending address. The only exit is reset.
- Arithmetic is modulo 2^XLEN: `0xFFFF_FFFC + 4` wraps to 0, and a negative `imm_ext` wraps the same way.
- Ignored inputs:
  - `imem_ack` outside FETCH.
  - `retire` outside HOLD.
- Reset values:
  - State FETCH; `pc=RESET_PC`; `instr_pc=RESET_PC`.
  - `instruction=NOP_INSTR`; `pc_plus4=RESET_PC+4`.
  - `instr_valid=0`, `halted=0`, `fetch_fault=0`.
  - `imem_req` is 1 immediately after reset release.

## Timing
- `imem_ack` may arrive in the same cycle `imem_req` rises (combinational memory). The fastest instruction takes 2 cycles: FETCH with ack, then HOLD with retire.
- `instruction`, `instr_pc`, `pc_plus4`, `instr_valid` are registered. They change only on the FETCH→HOLD edge, except `instr_valid`, which also falls on leaving HOLD.
- The new PC appears on `imem_addr` in the cycle after `retire`.
- `rst` asserted mid-fetch or mid-hold abandons the transaction asynchronously. Any `imem_ack` in the reset cycle is dropped.
- `halted` and `fetch_fault` are registered, asserted in the cycle after the triggering retire.

## Configuration
- Macro: `FETCH_MISALIGN_TRAP_EN`.
- Defined:
  - At retire, if `next[1:0] != 2'b00`, `pc<=next` and go to FAULT instead of FETCH.
  - Pcsrc 00 still takes priority (HALT).
- Undefined:
  - `next[1:0]` is forced to 00 before loading `pc`.
  - FAULT state is unreachable.
  - `fetch_fault` is tied to 0.

## Test plan
- Reset with `RESET_PC=0`, ack on the 3rd cycle of request, data 0x00500093 -> `imem_addr=0` held 3 cycles; then `instruction=0x00500093`, `instr_valid=1`, `pc_plus4=4`.
- Retire with `pcsrc=10` for three instructions under zero-wait ack -> addresses 0, 4, 8, 12; one instruction per 2 cycles.
- `instr_pc=0x10`, `imm_ext=0xFFFF_FFF8`, `pcsrc=01` -> next `imem_addr=0x08`. Separately, `pcsrc=11`, `alu_result=0x25` -> `imem_addr=0x24`.
- `pcsrc=00` on retire -> `halted=1` next cycle; `imem_req` stays 0 for 10 cycles despite stray ack/retire; `rst` clears to FETCH at `RESET_PC`.
- `pcsrc=01`, `instr_pc=0`, `imm_ext=2`:
  - With `FETCH_MISALIGN_TRAP_EN` -> `fetch_fault=1`, `imem_addr=0x2`, `imem_req=0`.
  - Without it -> fetch from 0x0.
- `rst` pulsed while `imem_req=1` and `imem_ack=1` -> `instruction` stays `NOP_INSTR`, `instr_valid=0`, PC=`RESET_PC`.
